// File: rtl/input_buffer_pkg.sv
// Shared router package: buffer geometry defaults and the direction encoding
// used by routing computation.
package input_buffer_pkg;

  localparam int IB_DATASIZE = 40;
  localparam int IB_WIDTH    = 3;
  localparam int IB_DEPTH    = 2 ** IB_WIDTH;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_S = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } dir_t;

endpackage

// File: rtl/input_buffer_if.sv
// Link-side and routing-computation-side signals of one router input port.
interface input_buffer_if
  import input_buffer_pkg::*;
#(
  parameter int DATASIZE = IB_DATASIZE,
  parameter int WIDTH    = IB_WIDTH
);

  logic [DATASIZE-1:0] data_in;
  logic                valid_in;
  logic                ready_out;
  logic [DATASIZE-1:0] data_out;
  logic                valid_out;
  logic                rc_ready;
  logic [WIDTH:0]      pressure_out;
  logic                overflow_err;

  modport master (
    output data_in, valid_in, rc_ready,
    input  ready_out, data_out, valid_out, pressure_out, overflow_err
  );

  modport slave (
    input  data_in, valid_in, rc_ready,
    output ready_out, data_out, valid_out, pressure_out, overflow_err
  );

endinterface

// File: rtl/input_buffer_mem.sv
// Flit storage: synchronous write, asynchronous read. Contents are not reset.
module input_buffer_mem #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                rc_clk,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_addr,
  input  logic [DATASIZE-1:0] wr_data,
  input  logic [WIDTH-1:0]    rd_addr,
  output logic [DATASIZE-1:0] rd_data
);

  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge rc_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/input_buffer.sv
// Per-port input FIFO: pointers, occupancy count, handshake and stall watchdog.
module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int DEPTH    = IB_DEPTH,
  parameter int WIDTH    = IB_WIDTH,
  parameter int DATASIZE = IB_DATASIZE
) (
  input  logic          rc_clk,
  input  logic          rst_n,
  input_buffer_if.slave bus
);

  localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] wr_ptr;
  logic [WIDTH-1:0] rd_ptr;
  logic [WIDTH:0]   count;
  logic [WIDTH:0]   stall_cnt;
  logic             overflow_q;
  logic             wr_en;
  logic             rd_en;
  logic             stalled;

  // ready_out depends on the registered count only: a pop never frees a slot
  // for a write in the same cycle.
  assign bus.ready_out    = (count != FULL_CNT) && rst_n;
  assign bus.valid_out    = (count != '0);
  assign bus.pressure_out = count;
  assign bus.overflow_err = overflow_q;

  assign wr_en   = bus.valid_in && bus.ready_out;
  assign rd_en   = bus.valid_out && bus.rc_ready;
  assign stalled = bus.valid_in && !bus.ready_out;

  input_buffer_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .DATASIZE (DATASIZE)
  ) u_mem (
    .rc_clk  (rc_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Watchdog is a down-counter reloaded whenever the port is not stalled;
  // reaching terminal count latches overflow_err until reset.
  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= FULL_CNT;
      overflow_q <= 1'b0;
    end else if (stalled) begin
      if (stall_cnt != '0) stall_cnt <= stall_cnt - 1'b1;
      if (stall_cnt == (WIDTH+1)'(1)) overflow_q <= 1'b1;
    end else begin
      stall_cnt <= FULL_CNT;
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Queue-model bench for input_buffer: per-cycle model compare plus directed literals.
module tb_input_buffer;

  logic rc_clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [39:0] mq [$];
  int          m_stall;
  bit          m_ovf;

  input_buffer_if bus ();

  input_buffer dut (
    .rc_clk (rc_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial rc_clk = 1'b0;
  always #5 rc_clk = ~rc_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most 8 flits; a write needs a free slot before the edge.
  always @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_stall = 0;
      m_ovf   = 1'b0;
    end else begin : upd
      bit can_wr;
      bit do_rd;
      can_wr = bus.valid_in && (mq.size() < 8);
      do_rd  = (mq.size() != 0) && bus.rc_ready;
      if (bus.valid_in && mq.size() == 8) begin
        if (m_stall < 8) m_stall++;
        if (m_stall == 8) m_ovf = 1'b1;
      end else begin
        m_stall = 0;
      end
      if (do_rd) void'(mq.pop_front());
      if (can_wr) mq.push_back(bus.data_in);
    end
  end

  always @(negedge rc_clk) begin
    if (rst_n !== 1'bx) begin
      chk("m_valid_out", 64'(bus.valid_out), 64'(mq.size() != 0));
      chk("m_ready_out", 64'(bus.ready_out), 64'((mq.size() < 8) && rst_n));
      chk("m_pressure", 64'(bus.pressure_out), 64'(mq.size()));
      chk("m_overflow", 64'(bus.overflow_err), 64'(m_ovf));
      if (mq.size() != 0) chk("m_data_out", 64'(bus.data_out), 64'(mq[0]));
    end
  end

  task automatic step(input bit v, input logic [39:0] d, input bit r);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.rc_ready = r;
    @(posedge rc_clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'bx;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.rc_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge rc_clk);
    #1;
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_ready", 64'(bus.ready_out), 64'd0);
    chk("rst_pressure", 64'(bus.pressure_out), 64'd0);
    chk("rst_overflow", 64'(bus.overflow_err), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(bus.ready_out), 64'd1);
    @(posedge rc_clk);
    #1;

    step(1'b1, 40'h01, 1'b0);
    chk("first_valid", 64'(bus.valid_out), 64'd1);
    step(1'b1, 40'h02, 1'b0);
    step(1'b1, 40'h03, 1'b0);
    chk("three_data", 64'(bus.data_out), 64'h01);
    chk("three_pressure", 64'(bus.pressure_out), 64'd3);

    for (int i = 4; i <= 8; i++) step(1'b1, 40'(i), 1'b0);
    chk("full_ready", 64'(bus.ready_out), 64'd0);
    chk("full_pressure", 64'(bus.pressure_out), 64'd8);

    for (int k = 1; k <= 7; k++) step(1'b1, 40'h09, 1'b0);
    chk("stall7_ovf", 64'(bus.overflow_err), 64'd0);
    step(1'b1, 40'h09, 1'b0);
    chk("stall8_ovf", 64'(bus.overflow_err), 64'd1);
    step(1'b1, 40'h09, 1'b0);
    chk("ovf_sticky", 64'(bus.overflow_err), 64'd1);

    step(1'b1, 40'h09, 1'b1);
    chk("fullpop_pressure", 64'(bus.pressure_out), 64'd7);
    chk("fullpop_ready", 64'(bus.ready_out), 64'd1);
    chk("fullpop_data", 64'(bus.data_out), 64'h02);
    step(1'b1, 40'h09, 1'b0);
    chk("pending_write", 64'(bus.pressure_out), 64'd8);

    for (int k = 0; k < 6; k++) step(1'b0, 40'h0, 1'b1);
    chk("drain2_pressure", 64'(bus.pressure_out), 64'd2);
    chk("drain2_data", 64'(bus.data_out), 64'h08);

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 40'(8'h10 + i), 1'b1);
      chk("stream_pressure", 64'(bus.pressure_out), 64'd2);
    end
    chk("stream_front", 64'(bus.data_out), 64'h22);

    step(1'b0, 40'h0, 1'b1);
    step(1'b0, 40'h0, 1'b1);
    chk("empty_valid", 64'(bus.valid_out), 64'd0);
    step(1'b1, 40'h55, 1'b1);
    chk("nobypass_pressure", 64'(bus.pressure_out), 64'd1);
    chk("nobypass_data", 64'(bus.data_out), 64'h55);
    step(1'b0, 40'h0, 1'b1);
    chk("consumed_pressure", 64'(bus.pressure_out), 64'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 40'(8'h60 + i), 1'b0);
    chk("five_pressure", 64'(bus.pressure_out), 64'd5);
    bus.valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.valid_out), 64'd0);
    chk("midrst_pressure", 64'(bus.pressure_out), 64'd0);
    chk("midrst_ready", 64'(bus.ready_out), 64'd0);
    chk("midrst_ovf", 64'(bus.overflow_err), 64'd0);
    @(posedge rc_clk);
    #1 rst_n = 1'b1;
    step(1'b1, 40'h77, 1'b0);
    chk("post_rst_data", 64'(bus.data_out), 64'h77);
    chk("post_rst_pressure", 64'(bus.pressure_out), 64'd1);
    step(1'b0, 40'h0, 1'b1);
    step(1'b0, 40'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
